// File: rtl/row_clear_engine.sv
// row_clear_engine: removes full playfield rows, shifting the rows above down by one.
// Ports: clk, rst_n (async, active low), start -> busy/done/lines_cleared;
//        mem_addr/mem_wdata/mem_we drive grid memory port A, mem_rdata is its 1-cycle registered read.
module row_clear_engine #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 20,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        lines_cleared,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [4:0]    LC_MAX   = 5'(HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN_RD, S_SCAN_CHK, S_CP_RD, S_CP_WR, S_CLR, S_DONE
    } state_t;

    state_t        r_state;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_dst;

    function automatic logic [ADDR_W-1:0] f_addr(
        input logic [RW-1:0] r,
        input logic [CW-1:0] c
    );
        logic [31:0] a;
        a = 32'(r) * 32'(WIDTH) + 32'(c);
        return a[ADDR_W-1:0];
    endfunction

    // The copy data is the word read in CP_RD, only valid during CP_WR,
    // so it is passed straight through rather than registered.
    assign mem_wdata = (r_state == S_CP_WR) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_dst         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        lines_cleared <= '0;
                        r_row         <= ROW_LAST;
                        r_col         <= '0;
                        busy          <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_addr      <= f_addr(ROW_LAST, '0);
                        r_state       <= S_SCAN_RD;
                    end
                end
                S_SCAN_RD: begin
                    r_state <= S_SCAN_CHK;
                end
                S_SCAN_CHK: begin
                    if (mem_rdata == '0) begin
                        if (r_row == '0) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row    <= r_row - 1'b1;
                            r_col    <= '0;
                            mem_addr <= f_addr(r_row - 1'b1, '0);
                            r_state  <= S_SCAN_RD;
                        end
                    end else if (r_col != COL_LAST) begin
                        r_col    <= r_col + 1'b1;
                        mem_addr <= f_addr(r_row, r_col + 1'b1);
                        r_state  <= S_SCAN_RD;
                    end else begin
                        if (lines_cleared != LC_MAX)
                            lines_cleared <= lines_cleared + 1'b1;
                        r_dst <= r_row;
                        r_col <= '0;
                        if (r_row == '0) begin
                            mem_addr <= '0;
                            mem_we   <= 1'b1;
                            r_state  <= S_CLR;
                        end else begin
                            mem_addr <= f_addr(r_row - 1'b1, '0);
                            r_state  <= S_CP_RD;
                        end
                    end
                end
                S_CP_RD: begin
                    mem_addr <= f_addr(r_dst, r_col);
                    mem_we   <= 1'b1;
                    r_state  <= S_CP_WR;
                end
                S_CP_WR: begin
                    if (r_col != COL_LAST) begin
                        r_col    <= r_col + 1'b1;
                        mem_addr <= f_addr(r_dst - 1'b1, r_col + 1'b1);
                        mem_we   <= 1'b0;
                        r_state  <= S_CP_RD;
                    end else begin
                        r_col <= '0;
                        r_dst <= r_dst - 1'b1;
                        if (r_dst == RW'(1)) begin
                            // Row 0 is reached: zero-fill it next.
                            mem_addr <= '0;
                            mem_we   <= 1'b1;
                            r_state  <= S_CLR;
                        end else begin
                            mem_addr <= f_addr(r_dst - RW'(2), '0);
                            mem_we   <= 1'b0;
                            r_state  <= S_CP_RD;
                        end
                    end
                end
                S_CLR: begin
                    if (r_col != COL_LAST) begin
                        r_col    <= r_col + 1'b1;
                        mem_addr <= ADDR_W'(r_col + 1'b1);
                    end else begin
                        // Rescan the same row: the shifted-in row may be full too.
                        r_col    <= '0;
                        mem_we   <= 1'b0;
                        mem_addr <= f_addr(r_row, '0);
                        r_state  <= S_SCAN_RD;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_clear_engine.sv
// tb_row_clear_engine: grid memory plus row_clear_engine, checked against a row-level model.
// Ports: none (top-level bench).
module tb_row_clear_engine;

    localparam int W = 10;
    localparam int H = 20;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, mem_we;
    logic [4:0] lines_cleared;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem [0:255];
    logic       ld_en = 1'b0;
    logic       ld_we = 1'b0;
    logic [7:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic       m_we;
    logic [7:0] m_addr, m_wdata;

    assign m_we    = ld_en ? ld_we   : mem_we;
    assign m_addr  = ld_en ? ld_addr : mem_addr;
    assign m_wdata = ld_en ? ld_data : mem_wdata;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_we) mem[m_addr] <= m_wdata;
        mem_rdata <= mem[m_addr];
    end

    row_clear_engine #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(8), .DATA_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .lines_cleared(lines_cleared),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] g  [N];
    logic [7:0] mg [N];
    int m_lc, m_cyc, m_we_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_g();
        for (int i = 0; i < N; i++) g[i] = 8'd0;
    endtask

    task automatic fill_row(input int r, input logic [7:0] v);
        for (int c = 0; c < W; c++) g[r*W + c] = v;
    endtask

    // Row-level model: final grid, lines removed, pass length and number of writes.
    task automatic model();
        int row, k;
        bit fin;
        for (int i = 0; i < N; i++) mg[i] = g[i];
        row = H - 1; m_lc = 0; m_cyc = 0; m_we_cnt = 0; fin = 0;
        while (!fin) begin
            k = -1;
            for (int c = 0; c < W; c++)
                if (k < 0 && mg[row*W + c] == 8'd0) k = c;
            if (k >= 0) begin
                m_cyc += 2 * (k + 1);
                if (row == 0) fin = 1;
                else row--;
            end else begin
                m_cyc += 2 * W;
                if (m_lc < H) m_lc++;
                for (int r = row; r > 0; r--)
                    for (int c = 0; c < W; c++) mg[r*W + c] = mg[(r-1)*W + c];
                for (int c = 0; c < W; c++) mg[c] = 8'd0;
                m_cyc    += 2 * W * row + W;
                m_we_cnt += W * row + W;
            end
        end
    endtask

    task automatic load();
        ld_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ld_addr = 8'(i);
            ld_data = g[i];
            ld_we   = 1'b1;
        end
        @(negedge clk);
        ld_we = 1'b0;
        ld_en = 1'b0;
    endtask

    // One full pass; lit_* < 0 skips the literal pin of the model.
    task automatic run_pass(input string nm, input int lit_lc, input int lit_cyc,
                            input int lit_we, input bit poke);
        int we_cnt, mism;
        load();
        model();
        if (lit_lc  >= 0) chk({nm, "_model_lc"},  m_lc,     lit_lc);
        if (lit_cyc >= 0) chk({nm, "_model_cyc"}, m_cyc,    lit_cyc);
        if (lit_we  >= 0) chk({nm, "_model_we"},  m_we_cnt, lit_we);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        we_cnt = 0;
        // e = rising edges since the edge that sampled start
        for (int e = 0; e <= m_cyc + 20; e++) begin
            if (e > 0) @(negedge clk);
            chk({nm, "_busy"}, busy, (e < m_cyc) ? 1 : 0);
            chk({nm, "_done"}, done, (e == m_cyc) ? 1 : 0);
            if (mem_we) we_cnt++;
            if (poke) begin
                if (e == 10) start = 1'b1;
                if (e == 11) start = 1'b0;
            end
        end
        chk({nm, "_writes"}, we_cnt, m_we_cnt);
        chk({nm, "_lines"}, lines_cleared, m_lc);
        mism = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== mg[i]) mism++;
        chk({nm, "_grid_mismatches"}, mism, 0);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: empty grid, done in the 41st cycle counting the start-edge cycle as 1
        clear_g();
        run_pass("t1_empty", 0, 40, 0, 0);

        // 2: single full bottom row, one cell above
        clear_g();
        fill_row(19, 8'd5);
        g[18*W + 3] = 8'd7;
        run_pass("t2_one", 1, 450, 200, 0);
        chk("t2_cell_19_3", mem[19*W + 3], 7);
        chk("t2_cell_19_2", mem[19*W + 2], 0);

        // 3: three stacked full rows with a lone cell above
        clear_g();
        fill_row(17, 8'd1);
        fill_row(18, 8'd2);
        fill_row(19, 8'd3);
        g[16*W] = 8'd9;
        run_pass("t3_three", 3, 1272, -1, 0);
        chk("t3_cell_19_0", mem[19*W], 9);

        // 4: holed row between two full rows
        clear_g();
        fill_row(17, 8'd3);
        fill_row(18, 8'd2);
        g[18*W + 9] = 8'd0;
        fill_row(19, 8'd1);
        run_pass("t4_hole", 2, -1, -1, 0);
        chk("t4_cell_19_8", mem[19*W + 8], 2);
        chk("t4_cell_19_9", mem[19*W + 9], 0);

        // 5: full grid with a start pulse during the pass
        for (int i = 0; i < N; i++) g[i] = 8'hFF;
        run_pass("t5_full", 20, -1, -1, 1);
        chk("t5_cell_0", mem[0], 0);

        // 6: reset during a copy write
        clear_g();
        fill_row(19, 8'd5);
        g[18*W + 3] = 8'd7;
        load();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !mem_we; i++) @(negedge clk);
        chk("t6_reach_cp_wr", mem_we, 1);
        chk("t6_lines_before", lines_cleared, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_we_async", mem_we, 0);
        chk("t6_busy_async", busy, 0);
        chk("t6_lines_async", lines_cleared, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_idle_busy", busy, 0);
            chk("t6_idle_done", done, 0);
            chk("t6_idle_we", mem_we, 0);
        end

        // 7: normal pass after the abort
        clear_g();
        run_pass("t7_after_rst", 0, 40, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
